// File: rtl/gc_sweep_ctrl.sv
// gc_sweep_ctrl: sequences vecmul_gc through Gibbs sweeps over every (node, colour-bit) pair
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, num_sweeps,         run request; sweep count and initial colours are
//   nodes_init                 sampled together with start in IDLE
//   row_addr                   weight-row address (memory answers one cycle later)
//   vm_nodes, vm_node_count,   colour state and pair under update, to the datapath
//   vm_color_bit_count
//   vm_product                 signed datapath result, captured in CALC
//   noise                      signed random term, added in UPDATE
//   nodes_out, flip_count      current colours and saturating count of changed bits
//   busy, done                 run in progress; one-cycle end-of-run pulse
module gc_sweep_ctrl #(
  parameter int PRECISION_BITS  = 4,
  parameter int OVERFLOW_BITS   = 4,
  parameter int NUM_NODES       = 4,
  parameter int NUM_NODES_BIT   = 2,
  parameter int NUM_COLORS      = 3,
  parameter int NUM_COLORS_BITS = 2,
  parameter int CBC_BITS        = 1,
  parameter int SWEEP_BITS      = 8,
  parameter int FLIP_BITS       = 16,
  localparam int PAD_BITS       = PRECISION_BITS + OVERFLOW_BITS,
  localparam int NW             = NUM_NODES * NUM_COLORS_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [SWEEP_BITS-1:0]      num_sweeps,
  input  logic [NW-1:0]              nodes_init,
  output logic [NUM_NODES_BIT-1:0]   row_addr,
  output logic [NW-1:0]              vm_nodes,
  output logic [NUM_NODES_BIT-1:0]   vm_node_count,
  output logic [CBC_BITS-1:0]        vm_color_bit_count,
  input  logic [PAD_BITS-1:0]        vm_product,
  input  logic [PAD_BITS-1:0]        noise,
  output logic [NW-1:0]              nodes_out,
  output logic                       busy,
  output logic                       done,
  output logic [FLIP_BITS-1:0]       flip_count
);
  typedef enum logic [2:0] {IDLE, FETCH, CALC, UPDATE, FINISH} state_t;
  state_t state_q, state_d;
  logic [NUM_NODES_BIT-1:0] n_q, n_d;
  logic [CBC_BITS-1:0] b_q, b_d;
  logic [SWEEP_BITS-1:0] s_q, s_d, sweeps_q, sweeps_d, s_inc;
  logic [NW-1:0] nodes_q, nodes_d;
  logic [FLIP_BITS-1:0] flip_q, flip_d;
  logic [PAD_BITS-1:0] product_q, product_d;
  logic [PAD_BITS:0] sum;
  logic [NUM_COLORS_BITS-1:0] old_c, cand;
  logic last_b, last_n;
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    b_d       = b_q;
    s_d       = s_q;
    sweeps_d  = sweeps_q;
    nodes_d   = nodes_q;
    flip_d    = flip_q;
    product_d = product_q;
    // one extra bit so the sum of two PAD_BITS signed values cannot overflow
    sum       = {product_q[PAD_BITS-1], product_q} + {noise[PAD_BITS-1], noise};
    old_c     = nodes_q[int'(n_q)*NUM_COLORS_BITS +: NUM_COLORS_BITS];
    cand      = old_c;
    cand[b_q] = !sum[PAD_BITS] && (|sum);
    last_b    = b_q == CBC_BITS'(NUM_COLORS_BITS - 1);
    last_n    = n_q == NUM_NODES_BIT'(NUM_NODES - 1);
    s_inc     = s_q + SWEEP_BITS'(1);
    case (state_q)
      IDLE: if (start) begin
        nodes_d  = nodes_init;
        sweeps_d = num_sweeps;
        flip_d   = '0;
        n_d      = '0;
        b_d      = '0;
        s_d      = '0;
        state_d  = num_sweeps == '0 ? FINISH : FETCH;
      end
      FETCH: state_d = CALC;
      CALC: begin
        product_d = vm_product;
        state_d   = UPDATE;
      end
      UPDATE: begin
        // illegal colour codes are rejected, leaving the node unchanged
        if ({1'b0, cand} < (NUM_COLORS_BITS+1)'(NUM_COLORS)) begin
          nodes_d[int'(n_q)*NUM_COLORS_BITS +: NUM_COLORS_BITS] = cand;
          if (cand != old_c && !(&flip_q)) flip_d = flip_q + FLIP_BITS'(1);
        end
        b_d = last_b ? '0 : b_q + CBC_BITS'(1);
        n_d = last_b ? (last_n ? '0 : n_q + NUM_NODES_BIT'(1)) : n_q;
        s_d = (last_b && last_n) ? s_inc : s_q;
        // s_inc compared before it is stored, so a full-scale count never wraps early
        state_d = (last_b && last_n && s_inc == sweeps_q) ? FINISH : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      sweeps_q  <= '0;
      nodes_q   <= '0;
      flip_q    <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      b_q       <= b_d;
      s_q       <= s_d;
      sweeps_q  <= sweeps_d;
      nodes_q   <= nodes_d;
      flip_q    <= flip_d;
      product_q <= product_d;
    end
  end
  assign row_addr           = n_q;
  assign vm_node_count      = n_q;
  assign vm_color_bit_count = b_q;
  assign vm_nodes           = nodes_q;
  assign nodes_out          = nodes_q;
  assign flip_count         = flip_q;
  assign busy               = state_q != IDLE;
  assign done               = state_q == FINISH;
endmodule

// File: tb/tb_gc_sweep_ctrl.sv
// tb_gc_sweep_ctrl: directed and randomized runs of gc_sweep_ctrl against a pair-level model
module tb_gc_sweep_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [7:0] num_sweeps = '0;
  logic [7:0] nodes_init = '0;
  logic [1:0] row_addr;
  logic [7:0] vm_nodes;
  logic [1:0] vm_node_count;
  logic [0:0] vm_color_bit_count;
  logic [7:0] vm_product = '0;
  logic [7:0] noise = '0;
  logic [7:0] nodes_out;
  logic busy, done;
  logic [15:0] flip_count;
  int checks = 0;
  int failures = 0;
  int P[2048];
  int N[2048];

  gc_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_sweeps(num_sweeps),
    .nodes_init(nodes_init), .row_addr(row_addr), .vm_nodes(vm_nodes),
    .vm_node_count(vm_node_count), .vm_color_bit_count(vm_color_bit_count),
    .vm_product(vm_product), .noise(noise), .nodes_out(nodes_out),
    .busy(busy), .done(done), .flip_count(flip_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Gibbs sweep model: pair k updates node (k/2)%4, bit k%2 using P[k]+N[k]
  task automatic model(input int init, input int sw, output int nodes, output int flips);
    int n, b, col, cand;
    nodes = init;
    flips = 0;
    for (int k = 0; k < sw * 8; k++) begin
      n = (k / 2) % 4;
      b = k % 2;
      col = (nodes >> (2 * n)) & 3;
      cand = (P[k] + N[k] > 0) ? (col | (1 << b)) : (col & ~(1 << b));
      if (cand < 3 && cand != col) begin
        nodes = (nodes & ~(3 << (2 * n))) | (cand << (2 * n));
        if (flips < 65535) flips++;
      end
    end
  endtask

  task automatic fill(input int p, input int nz, input bit rnd);
    for (int k = 0; k < 2048; k++) begin
      P[k] = rnd ? int'($urandom_range(255)) - 128 : p;
      N[k] = rnd ? int'($urandom_range(255)) - 128 : nz;
    end
  endtask

  task automatic run(input logic [7:0] init, input int sw, input bit glitch, input int abort_at);
    int c, k, exp_c, en, ef;
    bit got;
    model(int'(init), sw, en, ef);
    exp_c = 24 * sw + 1;
    @(negedge clk);
    start = 1'b1;
    nodes_init = init;
    num_sweeps = 8'(sw);
    vm_product = 8'(P[0]);
    noise = 8'(N[0]);
    @(negedge clk);
    start = 1'b0;
    c = 1;
    got = 0;
    while (c <= exp_c + 3 && !got) begin
      k = (c - 1) / 3;
      if (k < 2048) begin
        vm_product = 8'(P[k]);
        noise = 8'(N[k]);
      end
      start = glitch && (c == 5 || c == exp_c);
      nodes_init = ~init;
      num_sweeps = 8'(sw + 3);
      if (abort_at == c) begin
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_nodes", nodes_out, 0);
        chk("abort_flips", flip_count, 0);
        chk("abort_row", row_addr, 0);
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_done", done, 0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        return;
      end
      chk("busy_in_run", busy, 1);
      if ((c - 1) % 3 == 0 && k < sw * 8) begin
        chk("row_addr", row_addr, (k / 2) % 4);
        chk("node_count", vm_node_count, (k / 2) % 4);
        chk("color_bit", vm_color_bit_count, k % 2);
      end
      if (done) begin
        got = 1;
        chk("done_cycle", c, exp_c);
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    chk("busy_after", busy, 0);
    chk("done_pulse", done, 0);
    chk("nodes_out", nodes_out, en);
    chk("vm_nodes", vm_nodes, en);
    chk("flip_count", flip_count, ef);
  endtask

  initial begin
    logic [7:0] hold_nodes;
    logic [15:0] hold_flips;
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nodes", nodes_out, 0);
    chk("rst_vm_nodes", vm_nodes, 0);
    chk("rst_flips", flip_count, 0);
    chk("rst_row", row_addr, 0);
    chk("rst_ncount", vm_node_count, 0);
    chk("rst_bcount", vm_color_bit_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    fill(5, 0, 0);
    run(8'h00, 1, 0, 0);
    hold_nodes = nodes_out;
    hold_flips = flip_count;
    repeat (3) @(negedge clk);
    chk("hold_nodes", nodes_out, hold_nodes);
    chk("hold_flips", flip_count, hold_flips);

    fill(-5, 0, 0);
    run(8'h55, 2, 0, 0);
    fill(3, -3, 0);
    run(8'hAA, 1, 0, 0);
    run(8'h9C, 0, 0, 0);

    fill(0, 0, 1);
    run(8'(($urandom_range(255))), 2, 1, 0);
    run(8'h24, 1, 0, 10);
    run(8'h24, 1, 0, 0);

    for (int i = 0; i < 6; i++) begin
      fill(0, 0, 1);
      run(8'($urandom_range(255)), int'($urandom_range(1, 4)), i[0], 0);
    end

    fill(0, 0, 1);
    run(8'($urandom_range(255)), 255, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
